// File: rtl/wptr_manager_if.sv
// rtl/wptr_manager_if.sv - write-side bundle between the FIFO writer and the write-pointer manager
interface wptr_manager_if #(
  parameter int ADDR_W = 4
);
  logic              w_en;
  logic              ovf_clr;
  logic [ADDR_W:0]   g_rptr_async;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wcount;
  logic              wr_ack;
  logic              overflow;

  modport master (
    output w_en, ovf_clr, g_rptr_async,
    input  waddr, wptr, full, almost_full, wcount, wr_ack, overflow
  );

  modport slave (
    input  w_en, ovf_clr, g_rptr_async,
    output waddr, wptr, full, almost_full, wcount, wr_ack, overflow
  );
endinterface

// File: rtl/wptr_manager.sv
// rtl/wptr_manager.sv - async FIFO write-domain pointer, full/almost-full, occupancy and overflow logic
module wptr_manager #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12
) (
  input logic           wclk,
  input logic           wrst,
  wptr_manager_if.slave bus
);
  localparam int            PW      = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_TH);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] rq, rbin;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  // Stage 0 captures the raw read pointer; the last stage is the only one used.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.g_rptr_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  always_comb begin
    accept   = bus.w_en & ~full_q;
    wbin_d   = wbin_q + PW'(accept);
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    full_d   = (wptr_d == {~rq[PW-1:PW-2], rq[PW-3:0]});
    wcount_d = wbin_d - rbin;
    afull_d  = (wcount_d >= AFULL_V);
    ack_d    = accept;
    // A new overflow event beats a simultaneous clear.
    if (bus.w_en & full_q) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      sync_q   <= '0;
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.waddr       = wbin_q[ADDR_W-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wcount      = wcount_q;
  assign bus.wr_ack      = ack_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_manager.sv
// tb/tb_wptr_manager.sv - scoreboard bench for wptr_manager with an occupancy-arithmetic reference model
module tb_wptr_manager;
  logic wclk = 1'b0;
  logic wrst = 1'b1;

  wptr_manager_if #(.ADDR_W(4)) bus ();

  wptr_manager #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_TH(12)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       af;
    logic [4:0] wcount;
    logic       ack;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: pointers as plain integers mod 32, read pointer seen through a 2-deep delay line.
  int m_w    = 0;
  bit m_full = 0;
  bit m_ovf  = 0;
  int m_delay[$] = '{0, 0};
  int rd     = 0;

  function automatic int gray2bin(input int g);
    int b = g;
    int s = g >> 1;
    while (s != 0) begin
      b = b ^ s;
      s = s >> 1;
    end
    return b;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit clr, input int g);
    exp_t e;
    int   r;
    int   occ;
    bit   acc;
    if (rst) begin
      m_w = 0; m_full = 0; m_ovf = 0;
      m_delay = '{0, 0};
      e = '0;
    end else begin
      r   = gray2bin(m_delay[0]);
      acc = en && !m_full;
      if (en && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_w    = (m_w + int'(acc)) % 32;
      occ    = (m_w - r + 32) % 32;
      m_full = (occ == 16);
      e.waddr  = 4'(m_w % 16);
      e.wptr   = 5'(m_w ^ (m_w >> 1));
      e.full   = m_full;
      e.af     = (occ >= 12);
      e.wcount = 5'(occ);
      e.ack    = acc;
      e.ovf    = m_ovf;
      void'(m_delay.pop_front());
      m_delay.push_back(g);
    end
    sb.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input bit clr, input int g);
    wrst             = rst;
    bus.w_en         = en;
    bus.ovf_clr      = clr;
    bus.g_rptr_async = 5'(g);
    @(posedge wclk);
    model_edge(rst, en, clr, g);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  always @(negedge wclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a = {bus.waddr, bus.wptr, bus.full, bus.almost_full, bus.wcount, bus.wr_ack, bus.overflow};
      checks++;
      if (a === e) passes++;
      else $display("FAIL scoreboard t=%0t: got waddr=%0d wptr=%b full=%b af=%b wcount=%0d ack=%b ovf=%b want waddr=%0d wptr=%b full=%b af=%b wcount=%0d ack=%b ovf=%b",
                    $time, a.waddr, a.wptr, a.full, a.af, a.wcount, a.ack, a.ovf,
                    e.waddr, e.wptr, e.full, e.af, e.wcount, e.ack, e.ovf);
    end
  end

  task automatic random_traffic(input int n);
    bit rst;
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) rd = 0;
      else if (rd != m_w && $urandom_range(0, 1) == 1) rd = (rd + 1) % 32;
      step(rst, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rd ^ (rd >> 1));
      if (rst) rd = 0;
    end
  endtask

  initial begin
    bus.w_en = 0; bus.ovf_clr = 0; bus.g_rptr_async = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_wcount", int'(bus.wcount), 0);

    // Random traffic then a single-cycle reset.
    random_traffic(200);
    step(1, 1, 0, 0);
    chk("rst_all_zero", int'({bus.waddr, bus.wptr, bus.full, bus.almost_full, bus.wcount, bus.wr_ack, bus.overflow}), 0);
    rd = 0;

    // Fill with the read pointer held at zero.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0);
      if (i == 11) chk("af_before_12", int'(bus.almost_full), 0);
      if (i == 12) chk("af_at_12", int'(bus.almost_full), 1);
      if (i == 15) chk("full_before_16", int'(bus.full), 0);
    end
    chk("fill_full", int'(bus.full), 1);
    chk("fill_wcount", int'(bus.wcount), 16);
    chk("fill_wptr", int'(bus.wptr), 5'b11000);
    chk("fill_waddr", int'(bus.waddr), 0);

    // Overflow set / clear / set-beats-clear.
    step(0, 1, 0, 0);
    chk("ovf_ack", int'(bus.wr_ack), 0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_wptr_hold", int'(bus.wptr), 5'b11000);
    step(0, 0, 1, 0);
    chk("ovf_clr", int'(bus.overflow), 0);
    step(0, 1, 1, 0);
    chk("ovf_set_wins", int'(bus.overflow), 1);

    // Drain latency: one read-pointer step lands three edges later.
    step(0, 0, 0, 1);
    chk("drain_e1", int'(bus.full), 1);
    step(0, 0, 0, 1);
    chk("drain_e2", int'(bus.full), 1);
    step(0, 0, 0, 1);
    chk("drain_e3_full", int'(bus.full), 0);
    chk("drain_e3_wcount", int'(bus.wcount), 15);

    // Mid-operation reset while full with overflow set.
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("mid_full", int'(bus.full), 1);
    chk("mid_ovf", int'(bus.overflow), 1);
    step(1, 0, 0, 1);
    chk("mid_rst_zero", int'({bus.waddr, bus.wptr, bus.full, bus.almost_full, bus.wcount, bus.wr_ack, bus.overflow}), 0);
    step(0, 1, 0, 0);
    chk("post_rst_ack", int'(bus.wr_ack), 1);
    chk("post_rst_waddr", int'(bus.waddr), 1);

    // Wrap: 40 writes with the read pointer trailing.
    step(1, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      int g;
      g = (k >= 2) ? (k - 2) % 32 : 0;
      step(0, 1, 0, g ^ (g >> 1));
      chk("wrap_nofull", int'(bus.full), 0);
      chk("wrap_wcount_le5", int'(bus.wcount <= 5'd5), 1);
      if (k == 30) begin
        chk("wrap_wptr_top", int'(bus.wptr), 5'b10000);
        chk("wrap_waddr_15", int'(bus.waddr), 15);
      end
      if (k == 31) begin
        chk("wrap_wptr_zero", int'(bus.wptr), 0);
        chk("wrap_waddr_0", int'(bus.waddr), 0);
      end
    end

    step(1, 0, 0, 0);
    rd = 0;
    random_traffic(400);

    bus.w_en = 0; bus.ovf_clr = 0; wrst = 0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge wclk);
    #6;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wptr_manager.md
WPTR_MANAGER -- requirements
Module: wptr_manager

Interface
REQ-001 Parameter ADDR_W, default 4, FIFO address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops in the read-pointer synchroniser; legal range 2..4.
REQ-003 Parameter AFULL_TH, default 12, occupancy at or above which almost_full asserts; legal range 1..2^ADDR_W.
REQ-004 wclk  input  1  write-domain clock; the only clock, all state updates on its rising edge.
REQ-005 wrst  input  1  reset, synchronous, active-high.
REQ-006 w_en  input  1  write request.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 g_rptr_async  input  ADDR_W+1  Gray read pointer from the read domain, unsynchronised.
REQ-009 waddr  output  ADDR_W  RAM write address.
REQ-010 wptr  output  ADDR_W+1  registered Gray write pointer for the read domain.
REQ-011 full  output  1  registered full flag.
REQ-012 almost_full  output  1  registered almost-full flag.
REQ-013 wcount  output  ADDR_W+1  registered write-side occupancy, 0..2^ADDR_W.
REQ-014 wr_ack  output  1  one-cycle pulse, write accepted in the previous cycle.
REQ-015 overflow  output  1  sticky, a write was attempted while full.

Function
REQ-016 g_rptr_async passes through a SYNC_STAGES-deep flop chain; the last stage is rq.
REQ-017 rbin = Gray-to-binary(rq), combinational, ADDR_W+1 bits.
REQ-018 accept = w_en & ~full; wbin_next = wbin + accept, modulo 2^(ADDR_W+1).
REQ-019 Each cycle wbin <= wbin_next and wptr <= wbin_next ^ (wbin_next >> 1).
REQ-020 waddr = wbin[ADDR_W-1:0], combinational from the registered binary pointer.
REQ-021 full <= (Gray(wbin_next) == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}).
REQ-022 wcount <= (wbin_next - rbin) mod 2^(ADDR_W+1); almost_full <= (that difference >= AFULL_TH).
REQ-023 wr_ack <= accept.
REQ-024 overflow <= 1 when w_en & full; else 0 when ovf_clr; else hold; a set in the same cycle as ovf_clr wins.
REQ-025 A write while full leaves wbin, wptr and wcount unchanged and produces no wr_ack.
REQ-026 Pointer wrap from 2^(ADDR_W+1)-1 to 0 is seamless and causes no false full, almost_full or wcount value.
REQ-027 Read-pointer advance reaches full, almost_full and wcount after SYNC_STAGES+1 wclk edges; flags are pessimistic, never optimistic.
REQ-028 Simultaneous accepted write and read-pointer update: flags and count use the new wbin_next and the current rq in the same cycle.

Reset
REQ-029 With wrst high at a wclk edge, wbin, wptr, every sync stage, full, almost_full, wcount, wr_ack and overflow go to 0; waddr therefore becomes 0.
REQ-030 Reset has priority over every other input and takes effect mid-operation, including while full or overflow is set.

Verification (ADDR_W=4, SYNC_STAGES=2, AFULL_TH=12)
REQ-031 Reset: wrst=1 for 1 cycle after random traffic -> all outputs 0 at the next edge.
REQ-032 Fill: g_rptr_async=0, w_en=1 for 16 cycles -> almost_full=1 after the 12th accept, full=1 and wcount=16 after the 16th, wptr=5'b11000, waddr=0.
REQ-033 Overflow: while full, w_en=1 for 1 cycle -> wr_ack=0, pointer unchanged, overflow=1; then ovf_clr=1 -> overflow=0; w_en=1 together with ovf_clr while full -> overflow stays 1.
REQ-034 Drain latency: while full, set g_rptr_async=5'b00001 -> full=0 and wcount=15 exactly 3 edges later.
REQ-035 Wrap: 40 writes with the read pointer trailing by 4 -> wptr goes 5'b10000 then 5'b00000, waddr goes 15 then 0, full never asserts, wcount stays <= 5.
REQ-036 Mid-operation reset: wrst=1 while full and overflow=1 -> all 0 next edge; a write on the following cycle gives wr_ack=1 and waddr=1.
